// File: rtl/core_mem_router_pkg.sv
// Shared types and constants for the core data-port router: FSM states,
// default region map (memory, MMIO, timer) and the target-count limit.
package core_mem_router_pkg;

    localparam int MAX_TARGETS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Default three-region map; target 0 occupies the least significant slice.
    localparam logic [63:0] MEM_BASE   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MEM_MASK   = 64'hFFFF_FFFF_FFFF_F000;
    localparam logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000;
    localparam logic [63:0] MMIO_MASK  = 64'hFFFF_FFFF_F000_0000;
    localparam logic [63:0] TIMER_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TIMER_MASK = 64'hFFFF_FFFF_8000_0000;

    localparam logic [191:0] DEFAULT_REGION_BASE = {TIMER_BASE, MMIO_BASE, MEM_BASE};
    localparam logic [191:0] DEFAULT_REGION_MASK = {TIMER_MASK, MMIO_MASK, MEM_MASK};

    // Width of a target index; at least one bit so a single-target build still has a select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_mem_router_addr_region_decoder.sv
// Combinational address-region decoder: target i hits when
// (addr & MASK_i) == BASE_i; the lowest hitting index wins.
// Also intended for the instruction-fetch side.
module addr_region_decoder
    import core_mem_router_pkg::*;
#(
    parameter int                              ADDR_WIDTH  = 64,
    parameter int                              N_TARGETS   = 3,
    parameter logic [N_TARGETS*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [N_TARGETS*ADDR_WIDTH-1:0] REGION_MASK = DEFAULT_REGION_MASK
) (
    input  logic [ADDR_WIDTH-1:0]             addr_i,
    output logic                              hit_o,
    output logic [sel_width(N_TARGETS)-1:0]   sel_o
);

    localparam int SEL_W = sel_width(N_TARGETS);

    // Scan from the highest index down so the lowest hitting region is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int i = N_TARGETS - 1; i >= 0; i--) begin
            if ((addr_i & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(i);
            end else begin
                hit_o = hit_o;
            end
        end
    end

endmodule

// File: rtl/core_mem_router.sv
// Core data-port router: steers one load/store to one of N_TARGETS
// request/ack channels chosen by address region, holds the payload for the
// whole transaction and returns rdata/stall/err to the core.
// Optional ack timeout: define CORE_MEM_ROUTER_TIMEOUT_EN.
module core_mem_router
    import core_mem_router_pkg::*;
#(
    parameter int                              ADDR_WIDTH     = 64,
    parameter int                              DATA_WIDTH     = 64,
    parameter int                              N_TARGETS      = 3,
    parameter logic [N_TARGETS*ADDR_WIDTH-1:0] REGION_BASE    = DEFAULT_REGION_BASE,
    parameter logic [N_TARGETS*ADDR_WIDTH-1:0] REGION_MASK    = DEFAULT_REGION_MASK,
    parameter int                              TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [ADDR_WIDTH-1:0]             cpu_addr,
    input  logic                              cpu_wen,
    input  logic                              cpu_ren,
    input  logic [DATA_WIDTH-1:0]             cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0]           cpu_wmask,
    output logic [DATA_WIDTH-1:0]             cpu_rdata,
    output logic                              cpu_stall,
    output logic                              cpu_err,
    output logic [N_TARGETS-1:0]              tgt_req,
    output logic                              tgt_we,
    output logic [ADDR_WIDTH-1:0]             tgt_addr,
    output logic [DATA_WIDTH-1:0]             tgt_wdata,
    output logic [DATA_WIDTH/8-1:0]           tgt_wmask,
    input  logic [N_TARGETS-1:0]              tgt_ack,
    input  logic [N_TARGETS*DATA_WIDTH-1:0]   tgt_rdata
);

    localparam int MW    = DATA_WIDTH / 8;
    localparam int SEL_W = sel_width(N_TARGETS);

    state_e                  state_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [MW-1:0]           wmask_q;
    logic [N_TARGETS-1:0]    req_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic                    dec_hit_s;
    logic [SEL_W-1:0]        dec_sel_s;
    logic                    req_any_s;
    logic                    ack_sel_s;
    logic [DATA_WIDTH-1:0]   rdata_sel_s;
    logic                    timeout_s;

    addr_region_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_TARGETS  (N_TARGETS),
        .REGION_BASE(REGION_BASE),
        .REGION_MASK(REGION_MASK)
    ) u_decoder (
        .addr_i(cpu_addr),
        .hit_o (dec_hit_s),
        .sel_o (dec_sel_s)
    );

    // Only the selected target's ack and read-data slice matter.
    always_comb begin
        req_any_s   = cpu_wen | cpu_ren;
        ack_sel_s   = tgt_ack[sel_q];
        rdata_sel_s = tgt_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef CORE_MEM_ROUTER_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (TW_RAW < 8) ? 8 : TW_RAW;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Ack-wait counter: zero while idle so it starts at zero on BUSY entry, counts each BUSY cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Limit reached on the TIMEOUT_CYCLES-th BUSY cycle without an ack.
    always_comb begin
        timeout_s = (state_q == ST_BUSY) && (cnt_q == TO_LAST);
    end
`else
    // No timeout in this build: BUSY waits for the ack indefinitely.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Transaction FSM with registered target payload, rdata and error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (req_any_s) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        wmask_q <= cpu_wmask;
                        we_q    <= cpu_wen;
                        if (dec_hit_s) begin
                            sel_q   <= dec_sel_s;
                            req_q   <= N_TARGETS'(1) << dec_sel_s;
                            state_q <= ST_BUSY;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (ack_sel_s) begin
                        rdata_q <= we_q ? '0 : rdata_sel_s;
                        req_q   <= '0;
                        state_q <= ST_DONE;
                    end else if (timeout_s) begin
                        rdata_q <= '0;
                        req_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall follows the request combinationally in IDLE so the core holds it that same cycle.
    always_comb begin
        case (state_q)
            ST_IDLE: cpu_stall = req_any_s;
            ST_BUSY: cpu_stall = 1'b1;
            default: cpu_stall = 1'b0;
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign tgt_req   = req_q;
    assign tgt_we    = we_q;
    assign tgt_addr  = addr_q;
    assign tgt_wdata = wdata_q;
    assign tgt_wmask = wmask_q;

endmodule

// File: tb/tb_core_mem_router.sv
// Directed bench for core_mem_router with an expected-completion scoreboard.
module tb_core_mem_router;

    logic          clk = 1'b0;
    logic          rstn;
    logic [63:0]   cpu_addr;
    logic          cpu_wen;
    logic          cpu_ren;
    logic [63:0]   cpu_wdata;
    logic [7:0]    cpu_wmask;
    logic [63:0]   cpu_rdata;
    logic          cpu_stall;
    logic          cpu_err;
    logic [2:0]    tgt_req;
    logic          tgt_we;
    logic [63:0]   tgt_addr;
    logic [63:0]   tgt_wdata;
    logic [7:0]    tgt_wmask;
    logic [2:0]    tgt_ack;
    logic [191:0]  tgt_rdata;

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    core_mem_router #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (64),
        .N_TARGETS     (3),
        .REGION_BASE   ({64'h8000_0000, 64'h1000_0000, 64'h0}),
        .REGION_MASK   ({64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F000_0000, 64'hFFFF_FFFF_FFFF_F000}),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cpu_addr (cpu_addr),
        .cpu_wen  (cpu_wen),
        .cpu_ren  (cpu_ren),
        .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .cpu_err  (cpu_err),
        .tgt_req  (tgt_req),
        .tgt_we   (tgt_we),
        .tgt_addr (tgt_addr),
        .tgt_wdata(tgt_wdata),
        .tgt_wmask(tgt_wmask),
        .tgt_ack  (tgt_ack),
        .tgt_rdata(tgt_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected completion and compare it against the DUT outputs.
    task automatic chk_completion(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s observed=completion expected=empty_scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_err"},   {63'd0, cpu_err}, {63'd0, e.err});
            chk({tag, "_rdata"}, cpu_rdata, e.rdata);
        end
    endtask

    // One transaction starting #1 after an edge in IDLE; ends #1 after an edge back in IDLE.
    // exp_tgt < 0 means a decode miss; ack arrives on BUSY cycle ack_cycle.
    task automatic run_txn(input string tag, input logic w, input logic both,
                           input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm,
                           input int exp_tgt, input int ack_cycle, input logic [63:0] rd,
                           input logic wrong_ack);
        exp_t e;
        int   stall_cnt;
        logic [2:0] onehot;
        logic [63:0] exp_rd;
        exp_rd  = (exp_tgt < 0 || w) ? 64'd0 : rd;
        e.err   = (exp_tgt < 0) ? 1'b1 : 1'b0;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        onehot    = (exp_tgt < 0) ? 3'b000 : (3'b001 << exp_tgt);
        cpu_wen   = w;
        cpu_ren   = ~w | both;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wmask = wm;
        #1;
        chk({tag, "_idle_stall"}, {63'd0, cpu_stall}, 64'd1);
        stall_cnt = 1;
        @(posedge clk); #1;
        if (exp_tgt < 0) begin
            chk({tag, "_err_req"},   {61'd0, tgt_req}, 64'd0);
            chk({tag, "_err_stall"}, {63'd0, cpu_stall}, 64'd0);
            chk_completion(tag);
        end else begin
            for (int c = 1; c <= ack_cycle; c++) begin
                chk({tag, "_busy_req"},   {61'd0, tgt_req}, {61'd0, onehot});
                chk({tag, "_busy_we"},    {63'd0, tgt_we}, {63'd0, w});
                chk({tag, "_busy_addr"},  tgt_addr, a);
                chk({tag, "_busy_wdata"}, tgt_wdata, wd);
                chk({tag, "_busy_wmask"}, {56'd0, tgt_wmask}, {56'd0, wm});
                stall_cnt += int'(cpu_stall);
                cpu_addr  = ~a;
                cpu_wdata = ~wd;
                cpu_wmask = ~wm;
                tgt_rdata = {64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
                if (c == ack_cycle) begin
                    tgt_ack = onehot;
                    tgt_rdata[exp_tgt*64 +: 64] = rd;
                end else begin
                    tgt_ack = wrong_ack ? 3'b001 : 3'b000;
                end
                @(posedge clk); #1;
                tgt_ack = 3'b000;
            end
            chk({tag, "_done_req"},   {61'd0, tgt_req}, 64'd0);
            chk({tag, "_done_stall"}, {63'd0, cpu_stall}, 64'd0);
            chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(1 + ack_cycle));
            chk_completion(tag);
        end
        cpu_wen = 1'b0;
        cpu_ren = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_after_stall"}, {63'd0, cpu_stall}, 64'd0);
        chk({tag, "_after_err"},   {63'd0, cpu_err}, 64'd0);
        chk({tag, "_after_rdata"}, cpu_rdata, exp_rd);
    endtask

    initial begin
        rstn      = 1'b0;
        cpu_addr  = 64'd0;
        cpu_wen   = 1'b0;
        cpu_ren   = 1'b0;
        cpu_wdata = 64'd0;
        cpu_wmask = 8'd0;
        tgt_ack   = 3'b000;
        tgt_rdata = 192'd0;
        #2;
        chk("rst_req",   {61'd0, tgt_req}, 64'd0);
        chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
        chk("rst_err",   {63'd0, cpu_err}, 64'd0);
        chk("rst_rdata", cpu_rdata, 64'd0);
        chk("rst_addr",  tgt_addr, 64'd0);
        #20;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Read to memory, ack on the 6th BUSY cycle -> 7 stall cycles.
        run_txn("rd_t0", 1'b0, 1'b0, 64'h100, 64'd0, 8'd0, 0, 6, 64'hDEAD_BEEF, 1'b0);
        // Store to MMIO with the core changing its request mid-BUSY.
        run_txn("wr_t1", 1'b1, 1'b0, 64'h1000_0008, 64'h55, 8'h01, 1, 3, 64'h1234, 1'b0);
        // Decode miss.
        run_txn("miss", 1'b0, 1'b0, 64'h4000_0000, 64'd0, 8'd0, -1, 0, 64'd0, 1'b0);
        // Timer read with spurious acks from target 0.
        run_txn("wrong_ack", 1'b0, 1'b0, 64'h8000_0040, 64'd0, 8'd0, 2, 4, 64'hCAFE_F00D_0123_4567, 1'b1);
        // Both wen and ren: the write wins.
        run_txn("both", 1'b1, 1'b1, 64'h0FF8, 64'hFEED, 8'hF0, 0, 1, 64'h9999, 1'b0);

        // Acks while idle must not start anything.
        tgt_ack = 3'b111;
        @(posedge clk); #1;
        tgt_ack = 3'b000;
        chk("idle_ack_req", {61'd0, tgt_req}, 64'd0);
        chk("idle_ack_err", {63'd0, cpu_err}, 64'd0);

        // Asynchronous reset in the middle of BUSY.
        cpu_ren  = 1'b1;
        cpu_addr = 64'h8000_0010;
        @(posedge clk); #1;
        chk("rstmid_busy_req", {61'd0, tgt_req}, 64'd4);
        #3;
        rstn    = 1'b0;
        cpu_ren = 1'b0;
        #1;
        chk("rstmid_req",   {61'd0, tgt_req}, 64'd0);
        chk("rstmid_stall", {63'd0, cpu_stall}, 64'd0);
        @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_idle_req", {61'd0, tgt_req}, 64'd0);
        run_txn("post_rst", 1'b0, 1'b0, 64'h1000_0100, 64'd0, 8'd0, 1, 1, 64'h0BAD_F00D, 1'b0);

`ifdef CORE_MEM_ROUTER_TIMEOUT_EN
        // Never ack: ERR after 10 BUSY cycles.
        begin
            exp_t e;
            e.err   = 1'b1;
            e.rdata = 64'd0;
            exp_q.push_back(e);
            cpu_ren  = 1'b1;
            cpu_addr = 64'h200;
            @(posedge clk); #1;
            for (int c = 1; c <= 10; c++) begin
                chk("to_busy_stall", {63'd0, cpu_stall}, 64'd1);
                chk("to_busy_req",   {61'd0, tgt_req}, 64'd1);
                @(posedge clk); #1;
            end
            chk("to_req",   {61'd0, tgt_req}, 64'd0);
            chk("to_stall", {63'd0, cpu_stall}, 64'd0);
            chk_completion("timeout");
            cpu_ren = 1'b0;
            @(posedge clk); #1;
        end
        // Ack on the limit cycle wins.
        run_txn("to_ack10", 1'b0, 1'b0, 64'h300, 64'd0, 8'd0, 0, 10, 64'h7777_6666, 1'b0);
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
